// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite master adaptor: response codes,
// protection width and the write/read FSM state encodings.
package axi4_lite_pkg;

    localparam int PROT_W = 3;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef logic [1:0] w_state_t;
    localparam w_state_t W_IDLE = 2'd0;
    localparam w_state_t W_REQ  = 2'd1;
    localparam w_state_t W_RESP = 2'd2;

    typedef logic [1:0] r_state_t;
    localparam r_state_t R_IDLE = 2'd0;
    localparam r_state_t R_ADDR = 2'd1;
    localparam r_state_t R_DATA = 2'd2;

    // Any response other than OKAY is treated as an error by the capture logic.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != OKAY;
    endfunction

endpackage

// File: rtl/axi4_lite_vld_hold.sv
// Valid/payload holding register for one AXI4-Lite request channel.
// A load pulse captures the payload and raises valid; valid drops the cycle
// after the valid/ready handshake, and the payload is held until the next load.
module axi4_lite_vld_hold
    import axi4_lite_pkg::*;
#(
    parameter int PAYLOAD_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 ready,
    input  logic [PAYLOAD_W-1:0] payload_in,
    output logic                 valid,
    output logic [PAYLOAD_W-1:0] payload
);

    // Capture on load, retire valid on handshake, clear everything on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            payload <= '0;
        end else if (load) begin
            valid   <= 1'b1;
            payload <= payload_in;
        end else if (valid && ready) begin
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/axi4_lite_master_adaptor.sv
// Free-running AXI4-Lite master: repeatedly issues a write (AW+W, then B)
// and a read (AR, then R) built from static local request inputs.
// The write and read loops are independent FSMs; all outputs are registered.
// Optional capture of read data and responses: define AXI4_LITE_MASTER_RCAPTURE_EN.
module axi4_lite_master_adaptor
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    output logic [ADDR_WIDTH-1:0]   awaddr_out,
    output logic [PROT_W-1:0]       awprot_out,
    output logic                    awvalid_out,
    input  logic                    awready_in,
    input  logic [ADDR_WIDTH-1:0]   awaddr_in,
    input  logic [PROT_W-1:0]       awprot_in,
    output logic [DATA_WIDTH-1:0]   wdata_out,
    output logic [DATA_WIDTH/8-1:0] wstrb_out,
    output logic                    wvalid_out,
    input  logic                    wready_in,
    input  logic [DATA_WIDTH-1:0]   wdata_in,
    input  logic [DATA_WIDTH/8-1:0] wstrb_in,
    input  logic [1:0]              bresp_in,
    input  logic                    bvalid_in,
    output logic                    bready_out,
    output logic [ADDR_WIDTH-1:0]   araddr_out,
    output logic [PROT_W-1:0]       arprot_out,
    output logic                    arvalid_out,
    input  logic                    arready_in,
    input  logic [ADDR_WIDTH-1:0]   araddr_in,
    input  logic [PROT_W-1:0]       arprot_in,
    input  logic [DATA_WIDTH-1:0]   rdata_in,
    input  logic [1:0]              rresp_in,
    input  logic                    rvalid_in,
`ifdef AXI4_LITE_MASTER_RCAPTURE_EN
    output logic                    rready_out,
    output logic [DATA_WIDTH-1:0]   rdata_out,
    output logic [1:0]              rresp_out,
    output logic [1:0]              bresp_out,
    output logic                    resp_err_out
`else
    output logic                    rready_out
`endif
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int AX_W   = ADDR_WIDTH + PROT_W;
    localparam int WD_W   = DATA_WIDTH + STRB_W;

    // The active-high reset arrives on the port named aresetn.
    logic rst;
    assign rst = aresetn;

    w_state_t w_state;
    r_state_t r_state;

    logic aw_load, w_load, ar_load;
    logic aw_done, w_done;
    logic b_hs, r_hs, ar_hs;

    // A channel counts as done once its valid is low or it handshakes this edge.
    assign aw_load = (w_state == W_IDLE);
    assign w_load  = (w_state == W_IDLE);
    assign ar_load = (r_state == R_IDLE);
    assign aw_done = !awvalid_out || awready_in;
    assign w_done  = !wvalid_out  || wready_in;
    assign ar_hs   = arvalid_out && arready_in;
    assign b_hs    = bvalid_in && bready_out;
    assign r_hs    = rvalid_in && rready_out;

    axi4_lite_vld_hold #(.PAYLOAD_W(AX_W)) u_aw_hold (
        .clk        (aclk),
        .rst        (rst),
        .load       (aw_load),
        .ready      (awready_in),
        .payload_in ({awprot_in, awaddr_in}),
        .valid      (awvalid_out),
        .payload    ({awprot_out, awaddr_out})
    );

    axi4_lite_vld_hold #(.PAYLOAD_W(WD_W)) u_w_hold (
        .clk        (aclk),
        .rst        (rst),
        .load       (w_load),
        .ready      (wready_in),
        .payload_in ({wstrb_in, wdata_in}),
        .valid      (wvalid_out),
        .payload    ({wstrb_out, wdata_out})
    );

    axi4_lite_vld_hold #(.PAYLOAD_W(AX_W)) u_ar_hold (
        .clk        (aclk),
        .rst        (rst),
        .load       (ar_load),
        .ready      (arready_in),
        .payload_in ({arprot_in, araddr_in}),
        .valid      (arvalid_out),
        .payload    ({arprot_out, araddr_out})
    );

    // Write loop: launch AW+W, wait for both acceptances, then collect B.
    always_ff @(posedge aclk) begin
        if (rst) begin
            w_state    <= W_IDLE;
            bready_out <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: w_state <= W_REQ;
                W_REQ: begin
                    if (aw_done && w_done) begin
                        bready_out <= 1'b1;
                        w_state    <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        bready_out <= 1'b0;
                        w_state    <= W_IDLE;
                    end
                end
                default: begin
                    bready_out <= 1'b0;
                    w_state    <= W_IDLE;
                end
            endcase
        end
    end

    // Read loop: launch AR, then accept one R beat.
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_state    <= R_IDLE;
            rready_out <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: r_state <= R_ADDR;
                R_ADDR: begin
                    if (ar_hs) begin
                        rready_out <= 1'b1;
                        r_state    <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        rready_out <= 1'b0;
                        r_state    <= R_IDLE;
                    end
                end
                default: begin
                    rready_out <= 1'b0;
                    r_state    <= R_IDLE;
                end
            endcase
        end
    end

`ifdef AXI4_LITE_MASTER_RCAPTURE_EN
    // Capture read data/response and write response; errors are sticky until reset.
    always_ff @(posedge aclk) begin
        if (rst) begin
            rdata_out    <= '0;
            rresp_out    <= OKAY;
            bresp_out    <= OKAY;
            resp_err_out <= 1'b0;
        end else begin
            if (r_hs) begin
                rdata_out <= rdata_in;
                rresp_out <= rresp_in;
            end
            if (b_hs) begin
                bresp_out <= bresp_in;
            end
            if ((r_hs && resp_is_err(rresp_in)) || (b_hs && resp_is_err(bresp_in))) begin
                resp_err_out <= 1'b1;
            end
        end
    end
`else
    // Responses and read data are deliberately discarded in this build.
    logic unused_resp;
    assign unused_resp = ^{bresp_in, rresp_in, rdata_in};
`endif

endmodule

// File: tb/tb_axi4_lite_master_adaptor.sv
// Scoreboard bench for axi4_lite_master_adaptor: a transaction-level model
// pushes each launched request into a queue; a monitor pops on every DUT
// handshake and also compares all output levels each cycle.
module tb_axi4_lite_master_adaptor;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [AW-1:0] awaddr_out, awaddr_in, araddr_out, araddr_in;
    logic [2:0]    awprot_out, awprot_in, arprot_out, arprot_in;
    logic          awvalid_out, awready_in, wvalid_out, wready_in;
    logic [DW-1:0] wdata_out, wdata_in, rdata_in;
    logic [SW-1:0] wstrb_out, wstrb_in;
    logic [1:0]    bresp_in, rresp_in;
    logic          bvalid_in, bready_out, arvalid_out, arready_in, rvalid_in, rready_out;
`ifdef AXI4_LITE_MASTER_RCAPTURE_EN
    logic [DW-1:0] rdata_out;
    logic [1:0]    rresp_out, bresp_out;
    logic          resp_err_out;
`endif

    axi4_lite_master_adaptor #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr_out(awaddr_out), .awprot_out(awprot_out), .awvalid_out(awvalid_out),
        .awready_in(awready_in), .awaddr_in(awaddr_in), .awprot_in(awprot_in),
        .wdata_out(wdata_out), .wstrb_out(wstrb_out), .wvalid_out(wvalid_out),
        .wready_in(wready_in), .wdata_in(wdata_in), .wstrb_in(wstrb_in),
        .bresp_in(bresp_in), .bvalid_in(bvalid_in), .bready_out(bready_out),
        .araddr_out(araddr_out), .arprot_out(arprot_out), .arvalid_out(arvalid_out),
        .arready_in(arready_in), .araddr_in(araddr_in), .arprot_in(arprot_in),
        .rdata_in(rdata_in), .rresp_in(rresp_in), .rvalid_in(rvalid_in),
`ifdef AXI4_LITE_MASTER_RCAPTURE_EN
        .rready_out(rready_out), .rdata_out(rdata_out), .rresp_out(rresp_out),
        .bresp_out(bresp_out), .resp_err_out(resp_err_out)
`else
        .rready_out(rready_out)
`endif
    );

    always #5 aclk = ~aclk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    typedef struct { logic [AW-1:0] addr; logic [2:0] prot; } ax_t;
    typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; } wd_t;
    ax_t aw_q[$];
    ax_t ar_q[$];
    wd_t w_q[$];

    // Reference model state: what the master should be presenting this cycle.
    logic          m_aw_v = 0, m_w_v = 0, m_b_r = 0, m_ar_v = 0, m_r_r = 0;
    logic          m_w_busy = 0, m_r_busy = 0;
    logic [AW-1:0] m_awaddr = 0, m_araddr = 0;
    logic [2:0]    m_awprot = 0, m_arprot = 0;
    logic [DW-1:0] m_wdata = 0, m_rdata = 0;
    logic [SW-1:0] m_wstrb = 0;
    logic [1:0]    m_rresp = 0, m_bresp = 0;
    logic          m_err = 0;
    int            m_b_cnt = 0, m_r_cnt = 0, d_b_cnt = 0, d_r_cnt = 0;

    // Model: decide what the coming rising edge does, from the slave-side inputs.
    always @(negedge aclk) begin
        #1;
        if (aresetn) begin
            {m_aw_v, m_w_v, m_b_r, m_ar_v, m_r_r, m_w_busy, m_r_busy} = '0;
            m_awaddr = 0; m_awprot = 0; m_wdata = 0; m_wstrb = 0;
            m_araddr = 0; m_arprot = 0;
            m_rdata = 0; m_rresp = 0; m_bresp = 0; m_err = 0;
            aw_q.delete(); w_q.delete(); ar_q.delete();
        end else begin
            if (!m_w_busy) begin
                m_awaddr = awaddr_in; m_awprot = awprot_in;
                m_wdata  = wdata_in;  m_wstrb  = wstrb_in;
                m_aw_v = 1; m_w_v = 1; m_w_busy = 1;
                aw_q.push_back('{awaddr_in, awprot_in});
                w_q.push_back('{wdata_in, wstrb_in});
            end else if (m_b_r) begin
                if (bvalid_in) begin
                    m_b_r = 0; m_w_busy = 0; m_b_cnt++;
                    m_bresp = bresp_in; m_err |= (bresp_in != 2'b00);
                end
            end else begin
                if (m_aw_v && awready_in) m_aw_v = 0;
                if (m_w_v && wready_in)   m_w_v = 0;
                if (!m_aw_v && !m_w_v)    m_b_r = 1;
            end
            if (!m_r_busy) begin
                m_araddr = araddr_in; m_arprot = arprot_in;
                m_ar_v = 1; m_r_busy = 1;
                ar_q.push_back('{araddr_in, arprot_in});
            end else if (m_r_r) begin
                if (rvalid_in) begin
                    m_r_r = 0; m_r_busy = 0; m_r_cnt++;
                    m_rdata = rdata_in; m_rresp = rresp_in; m_err |= (rresp_in != 2'b00);
                end
            end else if (arready_in) begin
                m_ar_v = 0; m_r_r = 1;
            end
        end
    end

    // Monitor: compare output levels/payload and pop the scoreboard on handshakes.
    always @(negedge aclk) begin
        ax_t a;
        wd_t w;
        chk("awvalid", awvalid_out, m_aw_v);
        chk("wvalid",  wvalid_out,  m_w_v);
        chk("bready",  bready_out,  m_b_r);
        chk("arvalid", arvalid_out, m_ar_v);
        chk("rready",  rready_out,  m_r_r);
        chk("awaddr",  awaddr_out,  m_awaddr);
        chk("awprot",  awprot_out,  m_awprot);
        chk("wdata",   wdata_out,   m_wdata);
        chk("wstrb",   wstrb_out,   m_wstrb);
        chk("araddr",  araddr_out,  m_araddr);
        chk("arprot",  arprot_out,  m_arprot);
`ifdef AXI4_LITE_MASTER_RCAPTURE_EN
        chk("rdata_cap", rdata_out, m_rdata);
        chk("rresp_cap", rresp_out, m_rresp);
        chk("bresp_cap", bresp_out, m_bresp);
        chk("resp_err",  resp_err_out, m_err);
`endif
        if (!aresetn) begin
            if (awvalid_out && awready_in) begin
                if (aw_q.size() == 0) chk("aw_unexpected", 1, 0);
                else begin
                    a = aw_q.pop_front();
                    chk("aw_hs_addr", awaddr_out, a.addr);
                    chk("aw_hs_prot", awprot_out, a.prot);
                end
            end
            if (wvalid_out && wready_in) begin
                if (w_q.size() == 0) chk("w_unexpected", 1, 0);
                else begin
                    w = w_q.pop_front();
                    chk("w_hs_data", wdata_out, w.data);
                    chk("w_hs_strb", wstrb_out, w.strb);
                end
            end
            if (arvalid_out && arready_in) begin
                if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
                else begin
                    a = ar_q.pop_front();
                    chk("ar_hs_addr", araddr_out, a.addr);
                    chk("ar_hs_prot", arprot_out, a.prot);
                end
            end
            if (bvalid_in && bready_out) d_b_cnt++;
            if (rvalid_in && rready_out) d_r_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk);
            #2;
        end
    endtask

    task automatic slave(input logic awr, input logic wr, input logic bv,
                         input logic arr, input logic rv);
        awready_in = awr; wready_in = wr; bvalid_in = bv;
        arready_in = arr; rvalid_in = rv;
    endtask

    // Stimulus: directed scenarios from the test plan, then a randomized soak.
    initial begin
        aresetn = 1;
        awaddr_in = 0; awprot_in = 0; wdata_in = 0; wstrb_in = 0;
        araddr_in = 0; arprot_in = 0; rdata_in = 0; rresp_in = 0; bresp_in = 0;
        slave(0, 0, 0, 0, 0);
        step(2);

        // Stalled slave with an early B response, then one-cycle readies.
        aresetn   = 0;
        awaddr_in = 32'd16; awprot_in = 3'd4; wdata_in = 32'hF0B4A596; wstrb_in = 4'b1011;
        araddr_in = 32'd16; arprot_in = 3'd4;
        slave(0, 0, 1, 0, 0);
        step(12);
        slave(1, 1, 1, 1, 0);
        step(1);
        slave(0, 0, 1, 0, 0);
        rdata_in = 32'hF0B4A596;
        step(2);
        slave(0, 0, 0, 0, 1);
        step(1);
        slave(0, 0, 0, 0, 0);
        step(2);

        // Split handshakes: W accepted three cycles ahead of AW.
        slave(0, 1, 0, 0, 0);
        step(3);
        slave(1, 1, 0, 0, 0);
        step(1);
        slave(0, 0, 1, 0, 0);
        step(3);

        // Drive both loops into their response phases, then reset mid-flight.
        slave(1, 1, 0, 1, 0);
        step(4);
        aresetn = 1;
        awaddr_in = 32'h0000_0040; wdata_in = 32'h1234_5678; wstrb_in = 4'hF; araddr_in = 32'h80;
        step(1);
        aresetn = 0;
        slave(1, 1, 1, 1, 1);
        step(10);

        // Randomized soak with occasional resets and changing local inputs.
        for (int i = 0; i < 4000; i++) begin
            awaddr_in = $urandom; awprot_in = 3'($urandom); wdata_in = $urandom;
            wstrb_in  = 4'($urandom); araddr_in = $urandom; arprot_in = 3'($urandom);
            rdata_in  = $urandom; rresp_in = 2'($urandom); bresp_in = 2'($urandom);
            slave(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 1) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0));
            aresetn = ($urandom_range(0, 299) == 0);
            step(1);
        end
        aresetn = 0;
        slave(0, 0, 0, 0, 0);
        step(3);

        chk("write_completions", d_b_cnt, m_b_cnt);
        chk("read_completions",  d_r_cnt, m_r_cnt);
        chk("writes_progressed", (m_b_cnt > 100), 1);
        chk("reads_progressed",  (m_r_cnt > 100), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master_adaptor.md
Name: axi4_lite_master_adaptor

Overview:
- Free-running AXI4-Lite master adaptor.
- Converts static local request inputs (address, protection, data, strobe) into repeated, protocol-compliant AXI4-Lite write and read transactions on a slave-facing port.
- Write and read paths are independent state machines sharing one clock. The block sits between a local register/command source and an AXI4-Lite interconnect or slave.

Parameters:
- ADDR_WIDTH, 32, width of awaddr/araddr.
- DATA_WIDTH, 32, width of wdata/rdata; strobe width is DATA_WIDTH/8.

Ports:
- aclk  input  1  clock; all logic on rising edge.
- aresetn  input  1  synchronous, active-high reset; asserted when 1, sampled on the aclk rising edge.
- awaddr_out  output  ADDR_WIDTH  write address to slave.
- awprot_out  output  3  write protection.
- awvalid_out  output  1  write address valid.
- awready_in  input  1  slave write address ready.
- awaddr_in  input  ADDR_WIDTH  local write address.
- awprot_in  input  3  local write protection.
- wdata_out  output  DATA_WIDTH  write data.
- wstrb_out  output  DATA_WIDTH/8  write strobes.
- wvalid_out  output  1  write data valid.
- wready_in  input  1  slave write data ready.
- wdata_in  input  DATA_WIDTH  local write data.
- wstrb_in  input  DATA_WIDTH/8  local strobes.
- bresp_in  input  2  write response.
- bvalid_in  input  1  write response valid.
- bready_out  output  1  write response ready.
- araddr_out  output  ADDR_WIDTH  read address.
- arprot_out  output  3  read protection.
- arvalid_out  output  1  read address valid.
- arready_in  input  1  slave read address ready.
- araddr_in  input  ADDR_WIDTH  local read address.
- arprot_in  input  3  local read protection.
- rdata_in  input  DATA_WIDTH  read data.
- rresp_in  input  2  read response.
- rvalid_in  input  1  read data valid.
- rready_out  output  1  read data ready.

Behaviour:
- Reset: every output is 0 and both FSMs are in IDLE. Reset mid-transaction aborts immediately: valids and readies drop on the next edge, with no completion.
- All outputs are registered; no combinational path from any input to any output.
- Write FSM, states W_IDLE, W_REQ, W_RESP:
  - W_IDLE: unconditionally go to W_REQ next cycle. On that transition, latch awaddr_in, awprot_in, wdata_in, wstrb_in into the output registers and set awvalid_out=1 and wvalid_out=1.
  - W_REQ: AW and W handshakes are tracked independently.
    - awvalid_out clears the cycle after the first edge where awvalid_out and awready_in are both 1.
    - wvalid_out clears the cycle after its own handshake, same rule.
    - When both handshakes are done (simultaneous completion allowed), set bready_out=1 and go to W_RESP.
  - Payload stays stable while its valid is high. Valid never drops before its handshake.
  - W_RESP: on bvalid_in and bready_out both 1, clear bready_out and return to W_IDLE. bresp_in is ignored in the base build.
  - bvalid_in high before bready_out is asserted is ignored until W_RESP.
- Read FSM, states R_IDLE, R_ADDR, R_DATA:
  - R_IDLE: go to R_ADDR next cycle, latching araddr_in and arprot_in and setting arvalid_out=1.
  - R_ADDR: on the arvalid_out/arready_in handshake, clear arvalid_out, set rready_out=1 and go to R_DATA.
  - R_DATA: on the rvalid_in/rready_out handshake, clear rready_out and return to R_IDLE.
- Minimum loop time: 1 cycle IDLE + 1 handshake cycle + 1 response cycle, with back-to-back slave readies.
- Ready held high by the slave across multiple cycles completes exactly one handshake per valid assertion.

Optional Feature:
- Macro AXI4_LITE_MASTER_RCAPTURE_EN.
- When defined, the block adds outputs:
  - rdata_out[DATA_WIDTH-1:0] and rresp_out[1:0], loaded on each read data handshake.
  - bresp_out[1:0], loaded on each write response handshake.
  - resp_err_out, a sticky flag set when any captured response is nonzero.
- All added outputs reset to 0.
- When not defined, these ports and registers are absent and responses are ignored.

Decomposition:
- Package axi4_lite_pkg holds:
  - response constants: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - write FSM state typedef and read FSM state typedef;
  - the PROT width constant (3).
- One natural sub-module, axi4_lite_vld_hold: a valid/payload holding register with a load pulse and a ready input. It is instantiated for AW, W and AR.

Test Plan:
- Reset: aresetn=1 for 1 cycle -> all outputs 0, valids 0, readies 0.
- Write, slave stalling: awaddr_in=16, awprot_in=4, wdata_in=0xF0B4A596, wstrb_in=4'b1011, awready/wready low for 10 cycles. Required: awvalid_out=wvalid_out=1, with awaddr_out=16, awprot_out=4, wdata_out=0xF0B4A596 and wstrb_out=1011 held stable. Then both readies 1 -> valids drop next cycle, then bready_out=1.
- Early response: bvalid_in=1 asserted before AW/W acceptance -> ignored until W_RESP. Then bready_out high one cycle, FSM relaunches.
- Read: araddr_in=16, arprot_in=4, arready_in delayed 10 cycles -> arvalid_out held with araddr_out=16, arprot_out=4. On acceptance rready_out=1. rvalid_in=1 with rdata_in=0xF0B4A596 -> rready_out drops next cycle.
- Split handshakes: wready_in 3 cycles before awready_in -> wvalid_out drops first, bready_out asserts only after AW accepted.
- Reset mid-operation: aresetn=1 while in W_RESP/R_DATA -> outputs 0 next edge. After release, a new transaction starts with freshly latched inputs.
